// File: rtl/utc2gps_seq.sv
// utc2gps_seq: multi-cycle UTC (2000-2099) to GPS week/rollover/time-of-week converter
module utc2gps_seq #(
  parameter int LEAP_OFFSET = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  yy,
  input  logic [8:0]  doy,
  input  logic [4:0]  hh,
  input  logic [5:0]  mm,
  input  logic [5:0]  ss,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  wn10,
  output logic [2:0]  wn_ro,
  output logic [19:0] tow
);
  typedef enum logic [2:0] {IDLE, CHK, DAYS, SECS, DIV, OUT} state_t;
  localparam logic [31:0] WEEK_SEC = 32'd604800;
  state_t state, state_nx;
  logic [6:0] yy_r;
  logic [8:0] doy_r;
  logic [4:0] hh_r;
  logic [5:0] mm_r, ss_r;
  logic bad, leap, range_err, accept, fits;
  logic [15:0] days;
  logic [31:0] rem, div_sub;
  logic [12:0] week;
  logic [3:0] step;
  assign leap      = yy_r[1:0] == 2'd0;
  assign range_err = yy_r > 7'd99 || doy_r == 9'd0 || doy_r > (leap ? 9'd366 : 9'd365) ||
                     hh_r > 5'd23 || mm_r > 6'd59 || ss_r > 6'd59;
  assign accept    = state == IDLE && start && !done;
  assign div_sub   = WEEK_SEC << step;
  assign fits      = rem >= div_sub;
  assign busy      = state != IDLE || done;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // next-state: error short-circuits straight to OUT, divide runs until step 0
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? CHK : IDLE;
      CHK:     state_nx = range_err ? OUT : DAYS;
      DAYS:    state_nx = SECS;
      SECS:    state_nx = DIV;
      DIV:     state_nx = step == 4'd0 ? OUT : DIV;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: latch, check, accumulate, shift-subtract divide, publish
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {yy_r, doy_r, hh_r, mm_r, ss_r} <= '0;
      {bad, days, rem, week, step} <= '0;
      {done, err, wn10, wn_ro, tow} <= '0;
    end else begin
      done <= state == OUT;
      if (accept) {yy_r, doy_r, hh_r, mm_r, ss_r} <= {yy, doy, hh, mm, ss};
      if (state == CHK) bad <= range_err;
      if (state == DAYS)
        days <= 16'd365 * (16'd20 + 16'(yy_r)) + ((16'd23 + 16'(yy_r)) >> 2) + 16'(doy_r) - 16'd6;
      if (state == SECS) begin
        rem  <= 32'(days) * 32'd86400 + 32'(hh_r) * 32'd3600 + 32'(mm_r) * 32'd60 +
                32'(ss_r) + 32'(LEAP_OFFSET);
        week <= '0;
        step <= 4'd12;
      end
      if (state == DIV) begin
        rem  <= fits ? rem - div_sub : rem;
        week <= {week[11:0], fits};
        step <= step - 4'd1;
      end
      if (state == OUT) begin
        err <= bad;
        if (!bad) {wn10, wn_ro, tow} <= {week[9:0], week[12:10], rem[19:0]};
      end
    end
endmodule

// File: tb/tb_utc2gps_seq.sv
// tb_utc2gps_seq: randomized and directed checks of utc2gps_seq against a calendar model
module tb_utc2gps_seq;
  logic clk = 0, rst = 1, start = 0;
  logic [6:0] yy = 0;
  logic [8:0] doy = 0;
  logic [4:0] hh = 0;
  logic [5:0] mm = 0, ss = 0;
  logic busy, done, err;
  logic [9:0] wn10;
  logic [2:0] wn_ro;
  logic [19:0] tow;
  int errors = 0, checks = 0;
  int last_w10 = 0, last_ro = 0, last_tw = 0;

  utc2gps_seq #(.LEAP_OFFSET(18)) dut (
    .clk(clk), .rst(rst), .start(start), .yy(yy), .doy(doy), .hh(hh), .mm(mm), .ss(ss),
    .busy(busy), .done(done), .err(err), .wn10(wn10), .wn_ro(wn_ro), .tow(tow)
  );

  always #5 clk = ~clk;

  function automatic bit is_leap(int y);
    return (y % 4 == 0 && y % 100 != 0) || y % 400 == 0;
  endfunction

  function automatic longint gps_seconds(int y, int d, int h, int m, int s);
    longint days = 0;
    for (int yr = 1980; yr < 2000 + y; yr++) days += is_leap(yr) ? 366 : 365;
    days += d - 1 - 5;
    return days * 86400 + h * 3600 + m * 60 + s + 18;
  endfunction

  task automatic model(input int y, d, h, m, s, output int w10, ro, tw);
    longint sec = gps_seconds(y, d, h, m, s);
    longint wk = sec / 604800;
    w10 = int'(wk % 1024);
    ro  = int'(wk / 1024);
    tw  = int'(sec % 604800);
  endtask

  task automatic to_utc(input int w10, ro, tw, output int y, d, h, m, s);
    longint t = (longint'(ro) * 1024 + w10) * 604800 + tw - 18;
    longint dd = t / 86400 + 5;
    longint sd = t % 86400;
    int yr = 1980;
    while (dd >= (is_leap(yr) ? 366 : 365) && yr < 2200) begin
      dd -= is_leap(yr) ? 366 : 365;
      yr++;
    end
    y = yr - 2000;
    d = int'(dd) + 1;
    h = int'(sd / 3600);
    m = int'((sd / 60) % 60);
    s = int'(sd % 60);
  endtask

  task automatic run(input int y, d, h, m, s, output int lat);
    @(negedge clk);
    yy = 7'(y); doy = 9'(d); hh = 5'(h); mm = 6'(m); ss = 6'(s);
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, err, wn10, wn_ro, tow} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%0b done=%0b err=%0b wn10=%0d wn_ro=%0d tow=%0d, expected all 0",
               busy, done, err, wn10, wn_ro, tow);
    end
    rst = 0;
  endtask

  task automatic test_known;
    int ty[3]  = '{19, 0, 20};
    int td[3]  = '{96, 1, 366};
    int th[3]  = '{23, 0, 0};
    int tm[3]  = '{59, 0, 0};
    int ts[3]  = '{42, 0, 0};
    int e10[3] = '{0, 18, 90};
    int ero[3] = '{2, 1, 2};
    int etw[3] = '{0, 518418, 345618};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run(ty[i], td[i], th[i], tm[i], ts[i], lat);
      checks++;
      if (lat !== 17 || err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL known%0d_timing: lat=%0d err=%0b busy=%0b, expected lat=17 err=0 busy=1",
                 i, lat, err, busy);
      end
      checks++;
      if (int'(wn10) !== e10[i] || int'(wn_ro) !== ero[i] || int'(tow) !== etw[i]) begin
        errors++;
        $display("FAIL known%0d_value: wn10=%0d wn_ro=%0d tow=%0d, expected %0d %0d %0d",
                 i, wn10, wn_ro, tow, e10[i], ero[i], etw[i]);
      end
      last_w10 = e10[i]; last_ro = ero[i]; last_tw = etw[i];
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL known%0d_pulse: done=%0b busy=%0b one cycle later, expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_errors;
    int ty[6] = '{19, 5, 5, 100, 5, 7};
    int td[6] = '{366, 10, 10, 1, 0, 100};
    int th[6] = '{0, 24, 0, 0, 0, 0};
    int tm[6] = '{0, 0, 0, 0, 0, 60};
    int ts[6] = '{0, 0, 60, 0, 0, 0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run(ty[i], td[i], th[i], tm[i], ts[i], lat);
      checks++;
      if (lat !== 2 || err !== 1'b1 || int'(wn10) !== last_w10 || int'(wn_ro) !== last_ro ||
          int'(tow) !== last_tw) begin
        errors++;
        $display("FAIL err%0d: lat=%0d err=%0b out=%0d/%0d/%0d, expected lat=2 err=1 out=%0d/%0d/%0d",
                 i, lat, err, wn10, wn_ro, tow, last_w10, last_ro, last_tw);
      end
    end
  endtask

  task automatic test_back_to_back;
    int y = 23, d = 200, h = 13, m = 7, s = 31;
    int e10, ero, etw, nd = 0, dcyc = -1, g10 = 0, gro = 0, gtw = 0;
    model(y, d, h, m, s, e10, ero, etw);
    @(negedge clk);
    yy = 7'(y); doy = 9'(d); hh = 5'(h); mm = 6'(m); ss = 6'(s);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        dcyc = c;
        g10 = int'(wn10); gro = int'(wn_ro); gtw = int'(tow);
      end
      start = (c <= 5 || c == 17);
      if (start) begin
        yy = 7'($urandom_range(0, 99)); doy = 9'($urandom_range(1, 365));
        hh = 5'($urandom_range(0, 23)); mm = 6'($urandom_range(0, 59)); ss = 6'($urandom_range(0, 59));
      end
    end
    start = 0;
    checks++;
    if (nd !== 1 || dcyc !== 17) begin
      errors++;
      $display("FAIL b2b_done: done_count=%0d at_cycle=%0d, expected 1 at 17", nd, dcyc);
    end
    checks++;
    if (g10 !== e10 || gro !== ero || gtw !== etw) begin
      errors++;
      $display("FAIL b2b_value: got %0d/%0d/%0d, expected %0d/%0d/%0d", g10, gro, gtw, e10, ero, etw);
    end
    last_w10 = e10; last_ro = ero; last_tw = etw;
  endtask

  task automatic test_abort;
    int nd = 0, lat, e10, ero, etw;
    @(negedge clk);
    yy = 7'd50; doy = 9'd123; hh = 5'd4; mm = 6'd5; ss = 6'd6;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, wn10, wn_ro, tow} !== '0) begin
      errors++;
      $display("FAIL abort_reset: busy=%0b done=%0b err=%0b wn10=%0d wn_ro=%0d tow=%0d, expected all 0",
               busy, done, err, wn10, wn_ro, tow);
    end
    rst = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL abort_nodone: done_count=%0d, expected 0", nd);
    end
    model(50, 123, 4, 5, 6, e10, ero, etw);
    run(50, 123, 4, 5, 6, lat);
    checks++;
    if (lat !== 17 || err !== 1'b0 || int'(wn10) !== e10 || int'(wn_ro) !== ero || int'(tow) !== etw) begin
      errors++;
      $display("FAIL abort_rerun: lat=%0d err=%0b out=%0d/%0d/%0d, expected lat=17 err=0 out=%0d/%0d/%0d",
               lat, err, wn10, wn_ro, tow, e10, ero, etw);
    end
    last_w10 = e10; last_ro = ero; last_tw = etw;
  endtask

  task automatic test_random;
    int y, d, h, m, s, lat, e10, ero, etw, ry, rd, rh, rm, rs;
    for (int i = 0; i < 500; i++) begin
      y = $urandom_range(0, 99);
      d = $urandom_range(1, is_leap(2000 + y) ? 366 : 365);
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      s = $urandom_range(0, 59);
      model(y, d, h, m, s, e10, ero, etw);
      run(y, d, h, m, s, lat);
      checks++;
      if (lat !== 17 || err !== 1'b0 || int'(wn10) !== e10 || int'(wn_ro) !== ero || int'(tow) !== etw) begin
        errors++;
        $display("FAIL rand%0d %0d/%0d %0d:%0d:%0d: lat=%0d err=%0b out=%0d/%0d/%0d, expected lat=17 err=0 out=%0d/%0d/%0d",
                 i, y, d, h, m, s, lat, err, wn10, wn_ro, tow, e10, ero, etw);
      end
      to_utc(int'(wn10), int'(wn_ro), int'(tow), ry, rd, rh, rm, rs);
      checks++;
      if (ry !== y || rd !== d || rh !== h || rm !== m || rs !== s) begin
        errors++;
        $display("FAIL roundtrip%0d: back=%0d/%0d %0d:%0d:%0d, expected %0d/%0d %0d:%0d:%0d",
                 i, ry, rd, rh, rm, rs, y, d, h, m, s);
      end
    end
  endtask

  initial begin
    test_reset;
    test_known;
    test_errors;
    test_back_to_back;
    test_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
